// File: rtl/cnn_batch_norm_pkg.sv
// Shared types and constants for the batch-norm bias BRAM loader.
// The bank-index helper keeps the bank select at least one bit wide.
package cnn_batch_norm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RST = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } bn_load_state_t;

    localparam int BN_BRAM_NUM_DEFAULT = 4;
    localparam int BN_BANK_IDX_W       = $clog2(BN_BRAM_NUM_DEFAULT);

    function automatic int bank_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_batch_norm_bias_loader.sv
// Purpose: round-robin fill of the batch-norm bias BRAM banks from a valid/ready word stream.
// Latency: a bank write is presented 1 cycle after its word is accepted; o_done 1 cycle after the last write.
// Backpressure: o_data_ready is low outside LOAD and whenever i_reset_busy is high. Optional: BIAS_LOAD_CHECKSUM_EN.
module cnn_batch_norm_bias_loader
    import cnn_batch_norm_pkg::*;
#(
    parameter int OUTPUT_BRAM_NUM       = BN_BRAM_NUM_DEFAULT,
    parameter int DATA_WIDTH            = 32,
    parameter int BATCH_NORM_BIAS_WIDTH = 8
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [BATCH_NORM_BIAS_WIDTH-1:0] i_batch_norm_bias_size,
    input  logic                             i_reset_busy,
    input  logic                             i_data_valid,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_data_ready,
    output logic                             o_enable,
    output logic [OUTPUT_BRAM_NUM-1:0]       o_wenable,
    output logic [DATA_WIDTH-1:0]            o_bram_data,
    output logic [BATCH_NORM_BIAS_WIDTH-1:0] o_batch_norm_bias_data_point [OUTPUT_BRAM_NUM],
    output logic                             o_busy,
    output logic                             o_done
`ifdef BIAS_LOAD_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0]            o_checksum
`endif
);

    localparam int BW = bank_idx_width(OUTPUT_BRAM_NUM);

    bn_load_state_t                   state;
    bn_load_state_t                   state_nxt;
    logic [BATCH_NORM_BIAS_WIDTH-1:0] size_q;
    logic [BATCH_NORM_BIAS_WIDTH-1:0] word_cnt;
    logic [BW-1:0]                    bank;
    logic [OUTPUT_BRAM_NUM-1:0]       bank_onehot;
    logic                             accept;
    logic                             start_acc;
    logic                             last_word;

    assign bank      = word_cnt[BW-1:0];
    assign accept    = i_data_valid && o_data_ready;
    assign start_acc = (state == IDLE) && i_start;
    assign last_word = (word_cnt == size_q - BATCH_NORM_BIAS_WIDTH'(1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (i_start) state_nxt = (i_batch_norm_bias_size == '0) ? DONE : WAIT_RST;
            WAIT_RST: if (!i_reset_busy) state_nxt = LOAD;
            LOAD:     if (accept && last_word) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_data_ready = (state == LOAD) && !i_reset_busy;
    end

    always_comb begin
        bank_onehot       = '0;
        bank_onehot[bank] = 1'b1;
    end

    // Size is latched on start so a mid-load change on the input cannot move the end point.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            size_q      <= '0;
            word_cnt    <= '0;
            o_enable    <= 1'b0;
            o_wenable   <= '0;
            o_bram_data <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            for (int i = 0; i < OUTPUT_BRAM_NUM; i++) begin
                o_batch_norm_bias_data_point[i] <= '0;
            end
        end else begin
            o_enable  <= accept;
            o_wenable <= accept ? bank_onehot : '0;
            o_busy    <= (state_nxt != IDLE);
            o_done    <= (state == DONE);
            if (start_acc) begin
                size_q   <= i_batch_norm_bias_size;
                word_cnt <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt + BATCH_NORM_BIAS_WIDTH'(1);
            end
            if (accept) begin
                o_bram_data                        <= i_data;
                o_batch_norm_bias_data_point[bank] <= word_cnt;
            end
        end
    end

`ifdef BIAS_LOAD_CHECKSUM_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)        o_checksum <= '0;
        else if (start_acc) o_checksum <= '0;
        else if (accept)    o_checksum <= o_checksum ^ i_data;
    end
`endif

endmodule

// File: tb/tb_cnn_batch_norm_bias_loader.sv
// Directed bench for the bias loader; driver pushes expected writes/done into queues,
// a negedge monitor pops and compares whenever the DUT presents a write or done.
module tb_cnn_batch_norm_bias_loader;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int BNW = 8;

    typedef struct {
        int          bank;
        int          dp;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic            i_clock = 1'b0;
    logic            i_reset;
    logic            i_start;
    logic [BNW-1:0]  i_batch_norm_bias_size;
    logic            i_reset_busy;
    logic            i_data_valid;
    logic [DW-1:0]   i_data;
    logic            o_data_ready;
    logic            o_enable;
    logic [N-1:0]    o_wenable;
    logic [DW-1:0]   o_bram_data;
    logic [BNW-1:0]  o_batch_norm_bias_data_point [N];
    logic            o_busy;
    logic            o_done;
`ifdef BIAS_LOAD_CHECKSUM_EN
    logic [DW-1:0]   o_checksum;
`endif

    cnn_batch_norm_bias_loader #(
        .OUTPUT_BRAM_NUM(N), .DATA_WIDTH(DW), .BATCH_NORM_BIAS_WIDTH(BNW)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
        .i_batch_norm_bias_size(i_batch_norm_bias_size), .i_reset_busy(i_reset_busy),
        .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
        .o_enable(o_enable), .o_wenable(o_wenable), .o_bram_data(o_bram_data),
        .o_batch_norm_bias_data_point(o_batch_norm_bias_data_point),
        .o_busy(o_busy), .o_done(o_done)
`ifdef BIAS_LOAD_CHECKSUM_EN
       ,.o_checksum(o_checksum)
`endif
    );

    always #5 i_clock = ~i_clock;

    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    wr_t         wr_q[$];
    int          done_q[$];
    int          last_dp[N];
    logic [31:0] wv[16];

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write and every done pulse must match the head of its queue.
    always @(negedge i_clock) begin
        if (!i_reset && (o_enable || (o_wenable != '0))) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 64'(o_wenable), 64'(0));
            end else begin
                wr_t e;
                logic [N-1:0] oh;
                e  = wr_q.pop_front();
                oh = '0;
                oh[e.bank] = 1'b1;
                last_dp[e.bank] = e.dp;
                chk("write_cycle", 64'(cyc), 64'(e.cyc));
                chk("wenable", 64'({o_enable, o_wenable}), 64'({1'b1, oh}));
                chk("bram_data", 64'(o_bram_data), 64'(e.data));
                for (int b = 0; b < N; b++)
                    chk("data_point", 64'(o_batch_norm_bias_data_point[b]), 64'(last_dp[b]));
            end
        end
        if (!i_reset && o_done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 64'(o_done), 64'(0));
            end else begin
                chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                chk("busy_at_done", 64'(o_busy), 64'(0));
                chk("writes_drained_at_done", 64'(wr_q.size()), 64'(0));
            end
        end
    end

    task automatic check_all_zero(input string name);
        logic [BNW-1:0] dp_or;
        dp_or = '0;
        for (int b = 0; b < N; b++) dp_or |= o_batch_norm_bias_data_point[b];
        chk(name, 64'({o_enable, o_wenable, o_busy, o_done, o_data_ready}), 64'(0));
        chk({name, "_data"}, 64'({o_bram_data, dp_or}), 64'(0));
    endtask

    // vmode 0: valid always high; 1: valid toggles 1/0 each cycle.
    task automatic do_load(input int size, input int vmode, input int rb_hold,
                           input int abort_after, input bit csum_clear_chk);
        int k, n, guard, start_cyc, busy_cnt;
        @(posedge i_clock); #1;
        i_start = 1'b1;
        i_batch_norm_bias_size = BNW'(size);
        if (rb_hold > 0) i_reset_busy = 1'b1;
        @(negedge i_clock);
        start_cyc = cyc;
        if (size == 0) done_q.push_back(start_cyc + 2);
        @(posedge i_clock); #1;
        i_start = 1'b0;
        i_batch_norm_bias_size = BNW'(size + 3);
`ifdef BIAS_LOAD_CHECKSUM_EN
        if (csum_clear_chk) begin
            @(negedge i_clock);
            chk("checksum_cleared_on_start", 64'(o_checksum), 64'(0));
            @(posedge i_clock); #1;
        end
`endif
        if (size == 0) begin
            busy_cnt = 0;
            for (int j = 0; j < 4; j++) begin
                @(negedge i_clock);
                if (o_busy) busy_cnt++;
            end
            chk("size0_busy_cycles", 64'(busy_cnt), 64'(1));
            return;
        end
        for (int j = 0; j < rb_hold; j++) begin
            i_data_valid = 1'b1;
            i_data = wv[0];
            @(negedge i_clock);
            chk("ready_low_while_reset_busy", 64'(o_data_ready), 64'(0));
            @(posedge i_clock); #1;
        end
        i_reset_busy = 1'b0;
        k = 0; n = 0; guard = 0;
        while (k < size && guard < 200) begin
            i_data_valid = (vmode == 0) ? 1'b1 : ((n % 2) == 0);
            i_data = wv[k];
            n++;
            @(negedge i_clock);
            if (i_data_valid && o_data_ready) begin
                wr_q.push_back('{bank: k % N, dp: k, data: wv[k], cyc: cyc + 1});
                k++;
                if (k == size) done_q.push_back(cyc + 2);
            end
            @(posedge i_clock); #1;
            guard++;
            if (abort_after > 0 && k == abort_after) break;
        end
        i_data_valid = 1'b0;
        if (guard >= 200) chk("load_timeout", 64'(k), 64'(size));
        if (abort_after > 0) begin
            i_reset = 1'b1;
            #1;
            check_all_zero("async_reset_clear");
            wr_q.delete();
            done_q.delete();
            for (int b = 0; b < N; b++) last_dp[b] = 0;
            @(posedge i_clock); #1;
            i_reset = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 60; t++) begin
            @(negedge i_clock);
            if (wr_q.size() == 0 && done_q.size() == 0 && !o_busy) break;
        end
        if (t >= 60) chk("drain_timeout", 64'(wr_q.size() + done_q.size()), 64'(0));
        @(negedge i_clock);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_batch_norm_bias_size = '0;
        i_reset_busy = 1'b0; i_data_valid = 1'b0; i_data = '0;
        for (int b = 0; b < N; b++) last_dp[b] = 0;
        repeat (3) @(posedge i_clock);
        #1;
        check_all_zero("reset_state");
        i_reset = 1'b0;

        // 1: size 8, words 0x10..0x17, valid always
        for (int i = 0; i < 8; i++) wv[i] = 32'h10 + 32'(i);
        do_load(8, 0, 0, 0, 1'b0);
        wait_idle();

        // 2: size 0
        do_load(0, 0, 0, 0, 1'b0);
        wait_idle();

        // 3: reset-busy held 5 cycles, then size 4
        for (int i = 0; i < 4; i++) wv[i] = 32'hC0DE_0000 + 32'(i);
        do_load(4, 0, 5, 0, 1'b0);
        wait_idle();

        // 4: size 6, valid toggling
        for (int i = 0; i < 6; i++) wv[i] = 32'h5A00_0000 + 32'(i * 3);
        do_load(6, 1, 0, 0, 1'b0);
        wait_idle();

        // 5: reset after 3 of 8 words, then fresh size-2 load
        for (int i = 0; i < 8; i++) wv[i] = 32'hBEEF_0000 + 32'(i);
        do_load(8, 0, 0, 3, 1'b0);
        wv[0] = 32'h1111_2222; wv[1] = 32'h3333_4444;
        do_load(2, 0, 0, 0, 1'b0);
        wait_idle();

`ifdef BIAS_LOAD_CHECKSUM_EN
        // 6: checksum accumulate then clear on next start
        wv[0] = 32'hA5A5_A5A5; wv[1] = 32'h0F0F_0F0F;
        do_load(2, 0, 0, 0, 1'b0);
        wait_idle();
        chk("checksum_after_done", 64'(o_checksum), 64'(32'hAAAA_AAAA));
        wv[0] = 32'h0000_1234;
        do_load(1, 0, 0, 0, 1'b1);
        wait_idle();
        chk("checksum_single_word", 64'(o_checksum), 64'(32'h0000_1234));
`endif

        chk("final_queues_empty", 64'(wr_q.size() + done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
